regfile_wr_demux: RTL
=====================

Name: regfile_wr_demux

Overview:
- 32 x 32-bit general-purpose register file for the single-clock CPU datapath.
- The write side is a 5-bit to 32-way one-hot write-enable demultiplexer that steers a single write-data word into exactly one register. This is the inverse of the operand/writeback selection muxes.
- Two combinational read ports feed the ALU operand path.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W = 32

Ports:
- clk  input  1  system clock; all writes occur on its rising edge
- rst  input  1  asynchronous, active-high reset; clears every register
- we  input  1  write enable, sampled at rising clk
- wa  input  ADDR_W  write register address
- wd  input  DATA_W  write data
- ra1  input  ADDR_W  read address, port 1 (rs)
- ra2  input  ADDR_W  read address, port 2 (rt)
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2
- wr_onehot  output  2**ADDR_W  registered one-hot copy of the last committed write decode, for debug/trace

Behaviour:
- Reset (rst=1, asynchronous):
  - All registers 1..31 go to 0 immediately, without waiting for a clock edge.
  - wr_onehot goes to 0.
  - rd1 and rd2 therefore read 0 for any address while rst is high.
- Reset overrides writes. If rst is high at a rising clk edge, no write occurs, whatever the value of we.
- Reset released mid-cycle: the first write can commit at the next rising edge where rst=0.
- Write decode:
  - The demux produces dec[i] = we & (wa == i) for i = 0..31.
  - At most one bit of dec is set in any cycle.
- Write commit:
  - At a rising clk with rst=0, register i loads wd when dec[i]=1 and i != 0.
  - All other registers hold their value.
  - Write latency: the new value is visible on a read port from the cycle after the edge. It is not visible in the same cycle (see Optional Feature).
- Register 0:
  - Writes to address 0 are discarded and the storage is never updated.
  - Reads of address 0 return 0 under all conditions.
- wr_onehot:
  - At each rising clk with rst=0, wr_onehot <= dec with bit 0 forced to 0.
  - It is therefore all-zero after a cycle with no write or a write to address 0.
- Read ports:
  - Purely combinational from ra1/ra2 and register contents; zero-cycle latency.
  - The two ports are independent; ra1 == ra2 returns the same value on both ports.
- Simultaneous read and write of the same address, without the optional feature: the read returns the old value during that cycle and the new value after the edge.
- X handling: we=0 with an X on wa or wd must not corrupt any register.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN
- Defined:
  - If we=1, wa != 0 and ra1 == wa, rd1 returns wd combinationally in the same cycle. rd2 behaves the same way for ra2.
  - The bypass is inactive while rst=1; reads return 0 during reset.
  - Address 0 is never bypassed.
- Undefined: no bypass; behaviour is exactly as specified in Behaviour.

Test Plan:
1. Assert rst after writing 0xDEADBEEF to r5, asynchronously and between clock edges -> rd1 with ra1=5 drops to 0x00000000 before the next clk edge; wr_onehot = 0.
2. Write 0x12345678 to r7 with we=1, wa=7, then read with ra1=7 and ra2=7 on the next cycle -> rd1 = rd2 = 0x12345678; wr_onehot = 0x00000080.
3. Write 0xFFFFFFFF with we=1, wa=0, then read with ra1=0 -> rd1 = 0; wr_onehot = 0; a full sweep of r1..r31 shows no register changed.
4. Set we=0, wa=9, wd=0xAAAA5555 across 3 edges with r9 preloaded to 0x1 -> r9 still reads 0x1; wr_onehot = 0.
5. Hold ra1=3 while writing wd=0x55 to wa=3, with r3 previously 0x11:
   - Without the macro: rd1 = 0x11 in the write cycle, then 0x55.
   - With REGFILE_WR_BYPASS_EN: rd1 = 0x55 in the write cycle.
6. Walk one write per address 1..31 with wd = address * 0x01010101, then read all registers via both ports -> each register holds its own pattern and wr_onehot tracks 1 << address each cycle. Then assert rst and raise we=1 at the same edge -> the write is dropped and all reads return 0.

Source files
------------

// File: rtl/regfile_wr_demux.sv
// rtl/regfile_wr_demux.sv - 32x32 register file with one-hot write demux and two combinational read ports
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_wr_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [DATA_W-1:0]    wd,
  input  logic [ADDR_W-1:0]    ra1,
  input  logic [ADDR_W-1:0]    ra2,
  output logic [DATA_W-1:0]    rd1,
  output logic [DATA_W-1:0]    rd2,
  output logic [2**ADDR_W-1:0] wr_onehot
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  dec;
  logic [DATA_W-1:0] regs [DEPTH-1:1];

  // Gating every bit with we keeps an unknown wa from reaching any enable.
  always_comb begin
    dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dec[i] = we && (wa == ADDR_W'(i));
    end
  end

  // Register 0 has no storage at all, so it can never be written.
  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs[g] <= '0;
      end else if (dec[g]) begin
        regs[g] <= wd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_onehot <= '0;
    end else begin
      wr_onehot <= dec & ~DEPTH'(1);
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ra1 == ADDR_W'(i)) rd1 = regs[i];
      if (ra2 == ADDR_W'(i)) rd2 = regs[i];
    end
`ifdef REGFILE_WR_BYPASS_EN
    if (!rst && we && (wa != '0) && (ra1 == wa)) rd1 = wd;
    if (!rst && we && (wa != '0) && (ra2 == wa)) rd2 = wd;
`endif
    if (rst) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

endmodule
